inst_queue: RTL and testbench
=============================

// Module: inst_queue
// PURPOSE
// - Circular FIFO of {pc,inst} pairs between fetch (enqueue side) and decode (dequeue side).
// - Fetch pushes one 64-bit entry per cycle. The decoder pops one entry per cycle.
// - dequeue_rdata is a registered output that holds the most recently popped entry,
//   so the decoder consumes it the cycle after it asserts dequeue.
// - flush empties the queue on redirect.
// PARAMETERS
// - DEPTH   8   entries; power of 2, >= 2
// - DATA_W  64  entry width; {pc[63:32], inst[31:0]}
// PORTS
// - clk            in   1                  clock; all state updates on posedge
// - rst            in   1                  synchronous, active-low reset (0 = reset)
// - flush          in   1                  discard all entries (redirect)
// - enqueue        in   1                  push enqueue_wdata
// - enqueue_wdata  in   DATA_W             {pc,inst} from fetch
// - is_full        out  1                  registered; count == DEPTH
// - dequeue        in   1                  pop head entry into dequeue_rdata
// - dequeue_rdata  out  DATA_W             registered; last popped entry
// - is_empty       out  1                  registered; count == 0
// - count          out  $clog2(DEPTH)+1    registered occupancy
// - err            out  1                  sticky misuse flag; present only with INST_QUEUE_ERR_EN
// BEHAVIOUR
// - Storage: DEPTH x DATA_W array.
//   - wr_ptr and rd_ptr are $clog2(DEPTH)+1 bits; the MSB is the wrap bit.
//   - Index = ptr[$clog2(DEPTH)-1:0]; pointers wrap modulo 2*DEPTH.
//   - is_empty = (wr_ptr == rd_ptr).
//   - is_full = index bits equal and wrap bits differ.
//   - count = wr_ptr - rd_ptr, modulo 2*DEPTH.
// - Reset (rst==0 at posedge):
//   - wr_ptr = rd_ptr = 0, count = 0, is_empty = 1, is_full = 0.
//   - dequeue_rdata = 0, err = 0.
//   - Array contents are don't-care.
//   - Reset mid-stream discards all entries; the same posedge's enqueue/dequeue are ignored.
// - Accepted push: acc_enq = enqueue & (~is_full | acc_deq).
//   - A push to a full queue is accepted when a pop occurs in the same cycle.
// - Accepted pop: acc_deq = dequeue & ~is_empty.
//   - A pop from an empty queue is ignored; there is no bypass of the same-cycle push.
// - acc_enq: array[wr_ptr] <= enqueue_wdata; wr_ptr++.
// - acc_deq: dequeue_rdata <= array[rd_ptr]; rd_ptr++.
// - No accepted pop: dequeue_rdata holds its value.
// - Pop latency: entry visible on dequeue_rdata 1 cycle after the pop cycle.
// - Push-to-pop latency: an entry pushed in cycle N makes is_empty = 0 in N+1.
//   The earliest pop is in N+1, with data visible in N+2.
// - Simultaneous push and pop (non-empty): count is unchanged; both pointers advance.
//   Ordering is strictly FIFO.
// - Dropped push (full, no pop): state is unchanged and the entry is lost.
//   Fetch must gate enqueue with ~is_full.
// - flush (has priority over enqueue and dequeue in the same cycle):
//   - wr_ptr = rd_ptr = 0, count = 0.
//   - dequeue_rdata <= 0 (opcode 0 decodes to no request downstream).
//   - err is unaffected.
// - Status outputs are derived only from registered pointers; there is no combinational
//   path from enqueue or dequeue to is_empty, is_full or count.
// CONFIGURATION
// - `INST_QUEUE_ERR_EN defined:
//   - Adds port err.
//   - err <= 1 on any cycle with (enqueue & is_full & ~acc_deq) or (dequeue & is_empty),
//     when flush == 0.
//   - err is sticky until reset.
//   - Simulation also emits $error on the same condition.
// - `INST_QUEUE_ERR_EN undefined:
//   - Port err and its logic are absent.
//   - Misuse is silently ignored, as described in BEHAVIOUR.
// TESTING
// - Reset, then push 3 entries {0x60000000,0x00000013}, {0x60000004,..}, {0x60000008,..}.
//   -> count == 3; popping 3 times gives dequeue_rdata pcs 0x60000000, 0x60000004,
//      0x60000008 each 1 cycle after the pop; is_empty == 1 after the last pop.
// - Push 8 entries with DEPTH=8.
//   -> is_full == 1; a 9th push without a pop is dropped (count stays 8; err == 1 with _EN).
//   Then push and pop together while full.
//   -> count stays 8; order is preserved across the wrap.
// - Stream 20 entries with push and pop every cycle.
//   -> pointers wrap twice; popped sequence matches pushed sequence; count <= 1 throughout.
// - flush asserted with enqueue and dequeue while count == 5.
//   -> next cycle count == 0, is_empty == 1, dequeue_rdata == 0; the flush-cycle push is
//      not stored.
// - dequeue while empty, with enqueue in the same cycle.
//   -> dequeue_rdata unchanged; count == 1; err == 1 with _EN.
// - Assert rst=0 mid-stream with count == 4.
//   -> next cycle count == 0, is_empty == 1, is_full == 0, dequeue_rdata == 0.

Source files
------------

// File: rtl/inst_queue.sv
// -----------------------------------------------------------------------------
// inst_queue
// Circular FIFO of {pc, inst} pairs sitting between fetch (push side) and
// decode (pop side). One push and one pop per cycle. The popped entry lands
// in the registered dequeue_rdata one cycle after the pop is accepted.
//
// Ports
//   clk            clock, all state updates on posedge
//   rst            synchronous active-low reset (0 = reset)
//   flush          discard every entry (redirect); wins over push/pop
//   enqueue        push enqueue_wdata
//   enqueue_wdata  {pc[63:32], inst[31:0]} from fetch
//   is_full        registered, occupancy == DEPTH
//   dequeue        pop the head entry into dequeue_rdata
//   dequeue_rdata  registered, last popped entry (0 after reset/flush)
//   is_empty       registered, occupancy == 0
//   count          registered occupancy
//   err            sticky misuse flag (only with INST_QUEUE_ERR_EN)
//
// Configuration
//   INST_QUEUE_ERR_EN  when defined, adds the err port and misuse detection
// -----------------------------------------------------------------------------
module inst_queue #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       enqueue,
    input  logic [DATA_W-1:0]          enqueue_wdata,
    output logic                       is_full,
    input  logic                       dequeue,
    output logic [DATA_W-1:0]          dequeue_rdata,
    output logic                       is_empty,
    output logic [$clog2(DEPTH):0]     count
`ifdef INST_QUEUE_ERR_EN
    ,
    output logic                       err
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PW-1:0]     wr_ptr_r;
    logic [PW-1:0]     rd_ptr_r;
    logic [PW-1:0]     wr_ptr_nxt_s;
    logic [PW-1:0]     rd_ptr_nxt_s;
    logic              acc_enq_s;
    logic              acc_deq_s;
    logic [DATA_W-1:0] mem_r [DEPTH];

    function automatic logic f_empty(input logic [PW-1:0] wp, input logic [PW-1:0] rp);
        return (wp == rp);
    endfunction

    function automatic logic f_full(input logic [PW-1:0] wp, input logic [PW-1:0] rp);
        return (wp[AW-1:0] == rp[AW-1:0]) && (wp[AW] != rp[AW]);
    endfunction

    // Occupancy is the pointer distance modulo 2*DEPTH.
    function automatic logic [PW-1:0] f_count(input logic [PW-1:0] wp, input logic [PW-1:0] rp);
        return wp - rp;
    endfunction

    // Accept decisions and next pointer values.
    always_comb begin
        acc_deq_s    = dequeue & ~is_empty;
        // A pop in the same cycle frees the slot, so a push to a full queue is still taken.
        acc_enq_s    = enqueue & (~is_full | acc_deq_s);
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        if (flush) begin
            wr_ptr_nxt_s = {PW{1'b0}};
            rd_ptr_nxt_s = {PW{1'b0}};
        end else begin
            if (acc_enq_s) begin
                wr_ptr_nxt_s = wr_ptr_r + {{(PW-1){1'b0}}, 1'b1};
            end else begin
                wr_ptr_nxt_s = wr_ptr_r;
            end
            if (acc_deq_s) begin
                rd_ptr_nxt_s = rd_ptr_r + {{(PW-1){1'b0}}, 1'b1};
            end else begin
                rd_ptr_nxt_s = rd_ptr_r;
            end
        end
    end

    // Entry storage; contents are don't-care after reset so no reset here.
    always_ff @(posedge clk) begin
        if (rst && !flush && acc_enq_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= enqueue_wdata;
        end
    end

    // Pointers, status outputs and the popped-data register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_r      <= {PW{1'b0}};
            rd_ptr_r      <= {PW{1'b0}};
            is_empty      <= 1'b1;
            is_full       <= 1'b0;
            count         <= {PW{1'b0}};
            dequeue_rdata <= {DATA_W{1'b0}};
        end else begin
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            // Status is computed from the next pointers so the outputs are plain flops.
            is_empty <= f_empty(wr_ptr_nxt_s, rd_ptr_nxt_s);
            is_full  <= f_full(wr_ptr_nxt_s, rd_ptr_nxt_s);
            count    <= f_count(wr_ptr_nxt_s, rd_ptr_nxt_s);
            if (flush) begin
                // Zero decodes as "no request" downstream.
                dequeue_rdata <= {DATA_W{1'b0}};
            end else if (acc_deq_s) begin
                dequeue_rdata <= mem_r[rd_ptr_r[AW-1:0]];
            end
        end
    end

`ifdef INST_QUEUE_ERR_EN
    logic misuse_s;

    // Misuse: dropped push into a full queue, or pop from an empty queue.
    always_comb begin
        misuse_s = 1'b0;
        if (!flush) begin
            misuse_s = (enqueue & is_full & ~acc_deq_s) | (dequeue & is_empty);
        end else begin
            misuse_s = 1'b0;
        end
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            err <= 1'b0;
        end else if (misuse_s) begin
            err <= 1'b1;
`ifndef SYNTHESIS
            $error("inst_queue: misuse (push while full or pop while empty)");
`endif
        end
    end
`endif

endmodule

// File: tb/tb_inst_queue.sv
module tb_inst_queue;

    localparam int DEPTH  = 8;
    localparam int DATA_W = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              enqueue;
    logic [DATA_W-1:0] enqueue_wdata;
    logic              is_full;
    logic              dequeue;
    logic [DATA_W-1:0] dequeue_rdata;
    logic              is_empty;
    logic [3:0]        count;
`ifdef INST_QUEUE_ERR_EN
    logic              err;
`endif

    inst_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .enqueue       (enqueue),
        .enqueue_wdata (enqueue_wdata),
        .is_full       (is_full),
        .dequeue       (dequeue),
        .dequeue_rdata (dequeue_rdata),
        .is_empty      (is_empty),
        .count         (count)
`ifdef INST_QUEUE_ERR_EN
        ,
        .err           (err)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit check_en = 1'b0;

    // Reference: a plain queue of entries plus the last popped value.
    logic [DATA_W-1:0] q [$];
    logic [DATA_W-1:0] m_rdata = '0;
    bit                m_err   = 1'b0;

    // Model update on each rising edge using the inputs held since the falling edge.
    always @(posedge clk) begin
        bit was_full, was_empty, do_deq, do_enq;
        if (!rst) begin
            q.delete();
            m_rdata = '0;
            m_err   = 1'b0;
        end else if (flush) begin
            q.delete();
            m_rdata = '0;
        end else begin
            was_full  = (q.size() == DEPTH);
            was_empty = (q.size() == 0);
            do_deq    = dequeue && !was_empty;
            do_enq    = enqueue && (!was_full || do_deq);
            if ((enqueue && was_full && !do_deq) || (dequeue && was_empty)) m_err = 1'b1;
            if (do_deq) m_rdata = q.pop_front();
            if (do_enq) q.push_back(enqueue_wdata);
        end
    end

    // Every-cycle compare against the model, away from the rising edge.
    always @(negedge clk) begin
        if (check_en) begin
            total++;
            if (count !== 4'(q.size())) begin
                bad++;
                $display("FAIL count: got %0d want %0d at %0t", count, q.size(), $time);
            end
            total++;
            if (is_empty !== (q.size() == 0)) begin
                bad++;
                $display("FAIL is_empty: got %0b want %0b at %0t", is_empty, q.size() == 0, $time);
            end
            total++;
            if (is_full !== (q.size() == DEPTH)) begin
                bad++;
                $display("FAIL is_full: got %0b want %0b at %0t", is_full, q.size() == DEPTH, $time);
            end
            total++;
            if (dequeue_rdata !== m_rdata) begin
                bad++;
                $display("FAIL rdata: got %h want %h at %0t", dequeue_rdata, m_rdata, $time);
            end
`ifdef INST_QUEUE_ERR_EN
            total++;
            if (err !== m_err) begin
                bad++;
                $display("FAIL err: got %0b want %0b at %0t", err, m_err, $time);
            end
`endif
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // One cycle: drive on falling edge, return just after the rising edge.
    task automatic cyc(input bit r, input bit f, input bit e, input logic [63:0] w, input bit d);
        @(negedge clk);
        rst = r; flush = f; enqueue = e; enqueue_wdata = w; dequeue = d;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    initial begin
        rst = 1'b0; flush = 1'b0; enqueue = 1'b0; dequeue = 1'b0; enqueue_wdata = '0;

        // Reset state
        cyc(1'b0, 1'b0, 1'b0, 64'd0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 64'd0, 1'b0);
        check_en = 1'b1;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_empty", 64'(is_empty), 64'd1);
        chk("rst_full", 64'(is_full), 64'd0);
        chk("rst_rdata", dequeue_rdata, 64'd0);

        // Three pushes, then three pops with one-cycle data latency
        for (int i = 0; i < 3; i++)
            cyc(1'b1, 1'b0, 1'b1, {32'h6000_0000 + 32'(4 * i), 32'h0000_0013}, 1'b0);
        chk("push3_count", 64'(count), 64'd3);
        cyc(1'b1, 1'b0, 1'b0, 64'd0, 1'b1);
        chk("pop1_pc", 64'(dequeue_rdata[63:32]), 64'h6000_0000);
        cyc(1'b1, 1'b0, 1'b0, 64'd0, 1'b1);
        chk("pop2_pc", 64'(dequeue_rdata[63:32]), 64'h6000_0004);
        cyc(1'b1, 1'b0, 1'b0, 64'd0, 1'b1);
        chk("pop3_pc", 64'(dequeue_rdata[63:32]), 64'h6000_0008);
        chk("pop3_inst", 64'(dequeue_rdata[31:0]), 64'h0000_0013);
        chk("pop3_empty", 64'(is_empty), 64'd1);

        // Fill to DEPTH, drop a ninth push, then push+pop while full across the wrap
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b0, 1'b1, rnd64(), 1'b0);
        chk("fill_full", 64'(is_full), 64'd1);
        chk("fill_count", 64'(count), 64'd8);
        cyc(1'b1, 1'b0, 1'b1, 64'hDEAD_BEEF_0BAD_F00D, 1'b0);
        chk("drop_count", 64'(count), 64'd8);
        for (int i = 0; i < 12; i++) cyc(1'b1, 1'b0, 1'b1, rnd64(), 1'b1);
        chk("fullpp_count", 64'(count), 64'd8);
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b0, 1'b0, 64'd0, 1'b1);
        chk("drain_empty", 64'(is_empty), 64'd1);

        // Stream 20 entries with push and pop every cycle
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 1'b0, 1'b1, rnd64(), 1'b1);
            total++;
            if (count > 4'd1) begin
                bad++;
                $display("FAIL stream_count: got %0d want <=1", count);
            end
        end
        cyc(1'b1, 1'b0, 1'b0, 64'd0, 1'b1);

        // Flush with push and pop at count 5
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b1, rnd64(), 1'b0);
        chk("preflush_count", 64'(count), 64'd5);
        cyc(1'b1, 1'b1, 1'b1, 64'h1111_2222_3333_4444, 1'b1);
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_empty", 64'(is_empty), 64'd1);
        chk("flush_rdata", dequeue_rdata, 64'd0);

        // Pop while empty with a same-cycle push: no bypass
        cyc(1'b1, 1'b0, 1'b1, 64'h7000_0000_0000_0093, 1'b1);
        chk("emptypop_rdata", dequeue_rdata, 64'd0);
        chk("emptypop_count", 64'(count), 64'd1);
        cyc(1'b1, 1'b0, 1'b0, 64'd0, 1'b1);
        chk("bypass_later", dequeue_rdata, 64'h7000_0000_0000_0093);

        // Reset mid-stream at count 4, with push and pop ignored
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b1, rnd64(), 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 64'd0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, rnd64(), 1'b0);
        chk("prerst_count", 64'(count), 64'd4);
        cyc(1'b0, 1'b0, 1'b1, rnd64(), 1'b1);
        chk("midrst_count", 64'(count), 64'd0);
        chk("midrst_empty", 64'(is_empty), 64'd1);
        chk("midrst_full", 64'(is_full), 64'd0);
        chk("midrst_rdata", dequeue_rdata, 64'd0);

        // Randomized traffic; enqueue biased so full is reached regularly
        for (int i = 0; i < 600; i++) begin
            bit r, f, e, d;
            r = ($urandom_range(0, 199) != 0);
            f = ($urandom_range(0, 39) == 0);
            e = ($urandom_range(0, 9) < ((i / 100) % 2 == 0 ? 7 : 4));
            d = ($urandom_range(0, 9) < ((i / 100) % 2 == 0 ? 4 : 7));
            cyc(r, f, e, rnd64(), d);
        end

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
